// File: rtl/loby_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : loby_seq_ctrl
//  Purpose  : Command sequencer for one LoBy permutation core. Loads the key,
//             absorbs a valid/ready stream of message words using two-cycle
//             core commands, squeezes, and offers the tag on a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module loby_seq_ctrl #(
  parameter int KEY_W = 257,
  parameter int DIN_W = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [DIN_W-1:0] msg_data,
  input  logic             msg_valid,
  input  logic             msg_last,
  output logic             msg_ready,
  output logic [KEY_W-1:0] tag,
  output logic             tag_valid,
  input  logic             tag_ready,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt,
  output logic             core_init,
  output logic             core_sqz,
  output logic             core_din_valid,
  output logic [KEY_W-1:0] core_key,
  output logic [DIN_W-1:0] core_din,
  input  logic [KEY_W-1:0] core_dout
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // Each core command is an A (pulse) / B (hold) pair, because the core
  // registers its controls but consumes din/sqz combinationally one cycle later.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_KEY_A = 4'd1,
    S_KEY_B = 4'd2,
    S_WAIT  = 4'd3,
    S_ABS_A = 4'd4,
    S_ABS_B = 4'd5,
    S_SQZ_A = 4'd6,
    S_SQZ_B = 4'd7,
    S_TAG   = 4'd8
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_start_acc;
  logic   w_word_acc;

  // State register.
  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and the two handshake strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_word_acc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_KEY_A;
        end
      end
      S_KEY_A: w_state_nxt = S_KEY_B;
      S_KEY_B: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // msg_ready is high exactly while in WAIT, so this is the handshake.
        if (msg_valid && msg_ready) begin
          w_word_acc  = 1'b1;
          w_state_nxt = msg_last ? S_SQZ_A : S_ABS_A;
        end
      end
      S_ABS_A: w_state_nxt = S_ABS_B;
      S_ABS_B: w_state_nxt = S_WAIT;
      S_SQZ_A: w_state_nxt = S_SQZ_B;
      S_SQZ_B: w_state_nxt = S_TAG;
      S_TAG: begin
        if (tag_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered images of the state being entered, so they
  // line up with the state cycle-for-cycle without any output glitching.
  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      msg_ready      <= 1'b0;
      busy           <= 1'b0;
      core_init      <= 1'b0;
      core_din_valid <= 1'b0;
      core_sqz       <= 1'b0;
      tag_valid      <= 1'b0;
    end else begin
      msg_ready      <= (w_state_nxt == S_WAIT);
      busy           <= (w_state_nxt != S_IDLE);
      core_init      <= (w_state_nxt == S_KEY_A);
      core_din_valid <= (w_state_nxt == S_ABS_A) || (w_state_nxt == S_SQZ_A);
      core_sqz       <= (w_state_nxt == S_SQZ_A) || (w_state_nxt == S_SQZ_B);
      tag_valid      <= (w_state_nxt == S_TAG);
    end
  end

  // Key capture and the saturating absorbed-word counter.
  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      core_key <= '0;
      word_cnt <= '0;
    end else if (w_start_acc) begin
      core_key <= key;
      word_cnt <= '0;
    end else if (w_word_acc && (word_cnt != c_CNT_MAX)) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  // Message word register; held through the A/B pair that consumes it.
  always_ff @(posedge clk or posedge arstn) begin
    if (arstn)           core_din <= '0;
    else if (w_word_acc) core_din <= msg_data;
  end

  // Squeeze result is valid from the core during SQZ_B; it stays readable
  // after tag_valid drops until the next squeeze overwrites it.
  always_ff @(posedge clk or posedge arstn) begin
    if (arstn)                   tag <= '0;
    else if (r_state == S_SQZ_B) tag <= core_dout;
  end

endmodule
`default_nettype wire

// File: tb/tb_loby_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_loby_seq_ctrl
//  Purpose  : Self-checking bench for loby_seq_ctrl with a behavioural LoBy
//             core stand-in and a message-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_loby_seq_ctrl;

  localparam int KW = 257;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          arstn = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] key = '0;
  logic [DW-1:0] msg_data = '0;
  logic          msg_valid = 1'b0;
  logic          msg_last = 1'b0;
  logic          msg_ready;
  logic [KW-1:0] tag;
  logic          tag_valid;
  logic          tag_ready = 1'b0;
  logic          busy;
  logic [15:0]   word_cnt;
  logic          core_init, core_sqz, core_din_valid;
  logic [KW-1:0] core_key;
  logic [DW-1:0] core_din;
  logic [KW-1:0] core_dout;

  // Narrow-counter instance sharing the same stimulus and core response.
  logic          msg_ready2, tag_valid2, busy2, init2, sqz2, dv2;
  logic [KW-1:0] tag2, ckey2;
  logic [1:0]    word_cnt2;
  logic [DW-1:0] cdin2;

  always #5 clk = ~clk;

  loby_seq_ctrl #(.KEY_W(KW), .DIN_W(DW), .CNT_W(16)) dut (
    .clk(clk), .arstn(arstn), .start(start), .key(key),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_ready(msg_ready), .tag(tag), .tag_valid(tag_valid), .tag_ready(tag_ready),
    .busy(busy), .word_cnt(word_cnt), .core_init(core_init), .core_sqz(core_sqz),
    .core_din_valid(core_din_valid), .core_key(core_key), .core_din(core_din),
    .core_dout(core_dout));

  loby_seq_ctrl #(.KEY_W(KW), .DIN_W(DW), .CNT_W(2)) dut2 (
    .clk(clk), .arstn(arstn), .start(start), .key(key),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_ready(msg_ready2), .tag(tag2), .tag_valid(tag_valid2), .tag_ready(tag_ready),
    .busy(busy2), .word_cnt(word_cnt2), .core_init(init2), .core_sqz(sqz2),
    .core_din_valid(dv2), .core_key(ckey2), .core_din(cdin2),
    .core_dout(core_dout));

  // Toy permutation step: absorb one word into the state.
  function automatic logic [KW-1:0] mix(input logic [KW-1:0] s, input logic [DW-1:0] w);
    return {s[KW-2:0], s[KW-1]} ^ {1'b1, w, ~w, w ^ 64'hA5A5_A5A5_5A5A_5A5A, w};
  endfunction

  function automatic logic [KW-1:0] rkey();
    logic [287:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return t[KW-1:0];
  endfunction

  // Core stand-in: controls registered one cycle, din/sqz used combinationally.
  logic          c_init_q, c_dv_q, c_sqz_q;
  logic [KW-1:0] c_st;
  always @(posedge clk or posedge arstn) begin
    if (arstn) begin
      c_init_q <= 1'b0; c_dv_q <= 1'b0; c_sqz_q <= 1'b0; c_st <= '0;
    end else begin
      c_init_q <= core_init; c_dv_q <= core_din_valid; c_sqz_q <= core_sqz;
      if (c_init_q)    c_st <= core_key;
      else if (c_dv_q) c_st <= mix(c_st, core_din);
    end
  end
  assign core_dout = (c_sqz_q && core_sqz && c_dv_q) ? mix(c_st, core_din) : '0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_init = 0;

  task automatic chk(input string nm, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  // Cycle-level protocol monitor (A/B pairing, pulse widths).
  logic          p_dv = 0, p_init = 0, p_sqza = 0, p_sqzb = 0;
  logic [DW-1:0] p_din = '0;
  always @(negedge clk) begin
    if (arstn) begin
      p_dv = 0; p_init = 0; p_sqza = 0; p_sqzb = 0;
    end else begin
      if (p_dv) begin
        chk("din_held_B", core_din, p_din);
        chk("dv_low_B", core_din_valid, 0);
      end
      if (p_init) chk("init_1cyc", core_init, 0);
      if (p_sqza) chk("sqz_held_B", core_sqz, 1);
      if (p_sqzb) chk("tagv_after_sqzB", {tag_valid, core_sqz}, 2'b10);
      if (core_init) n_init++;
      p_dv   = core_din_valid;
      p_din  = core_din;
      p_init = core_init;
      p_sqza = core_sqz && core_din_valid;
      p_sqzb = core_sqz && !core_din_valid;
    end
  end

  task automatic do_reset();
    @(negedge clk); #2 arstn = 1'b1;
    start = 0; msg_valid = 0; msg_last = 0; tag_ready = 0;
    @(negedge clk); @(negedge clk); #2 arstn = 1'b0;
    @(negedge clk);
  endtask

  // One full message: start, absorb n words, squeeze, hand off the tag.
  task automatic run_msg(input int n, input int gmax, input int tdelay, input bit noise,
                         input bit fixed, input int exp_cnt, input int exp_cnt2);
    logic [KW-1:0] k, exp_tag;
    logic [DW-1:0] w;
    logic [DW-1:0] words[$];
    int cyc, g, init0;
    k = rkey();
    init0 = n_init;
    start = 1; key = k;
    @(negedge clk);
    start = 0; key = rkey();
    chk("keyA_init", {busy, core_init}, 2'b11);
    for (int i = 0; i < n; i++) begin
      w = (fixed && i == 0) ? 64'h0123_4567_89AB_CDEF : {$urandom(), $urandom()};
      g = (gmax == 0) ? 0 : $urandom_range(0, gmax);
      for (int j = 0; j < g; j++) begin
        msg_valid = 0; start = noise;
        @(negedge clk);
      end
      msg_valid = 1; msg_data = w; msg_last = (i == n - 1); start = noise;
      cyc = 0;
      while (!msg_ready && cyc < 40) begin @(negedge clk); cyc++; end
      if (cyc >= 40) begin
        chk("msg_ready_timeout", 0, 1);
        do_reset();
        return;
      end
      if (gmax == 0 && i > 0) chk("ready_1in3", cyc, 2);
      words.push_back(w);
      @(negedge clk);
      chk("ready_drop", msg_ready, 0);
    end
    msg_valid = 0; msg_last = 0; start = 0;
    exp_tag = k;
    foreach (words[i]) exp_tag = mix(exp_tag, words[i]);
    cyc = 0;
    while (!tag_valid && cyc < 20) begin @(negedge clk); cyc++; end
    if (cyc >= 20) begin
      chk("tag_valid_timeout", 0, 1);
      do_reset();
      return;
    end
    for (int d = 0; d < tdelay; d++) begin
      chk("hold_tag", tag, exp_tag);
      chk("hold_flags", {tag_valid, msg_ready, busy}, 3'b101);
      start = noise; key = rkey(); msg_valid = noise;
      @(negedge clk);
    end
    start = 0; msg_valid = 0;
    chk("tag", tag, exp_tag);
    chk("tag_cnt2", tag2, exp_tag);
    tag_ready = 1;
    @(negedge clk);
    tag_ready = 0;
    chk("idle_after_tag", {busy, tag_valid}, 2'b00);
    chk("tag_readable", tag, exp_tag);
    chk("word_cnt", word_cnt, exp_cnt);
    chk("word_cnt_sat2", word_cnt2, exp_cnt2);
    chk("core_key", core_key, k);
    chk("init_pulses", n_init - init0, 1);
    @(negedge clk);
  endtask

  typedef struct {
    int n; int gmax; int tdelay; bit noise; bit fixed; int cnt; int cnt2;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   n;
    tbl[0] = '{n:1, gmax:0, tdelay:0,  noise:0, fixed:1, cnt:1, cnt2:1};
    tbl[1] = '{n:4, gmax:0, tdelay:0,  noise:0, fixed:0, cnt:4, cnt2:3};
    tbl[2] = '{n:2, gmax:1, tdelay:10, noise:1, fixed:0, cnt:2, cnt2:2};
    tbl[3] = '{n:3, gmax:2, tdelay:0,  noise:1, fixed:0, cnt:3, cnt2:3};
    tbl[4] = '{n:5, gmax:0, tdelay:1,  noise:1, fixed:0, cnt:5, cnt2:3};
    tbl[5] = '{n:6, gmax:3, tdelay:2,  noise:0, fixed:0, cnt:6, cnt2:3};

    // Power-on reset values.
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, msg_ready, tag_valid, core_init, core_sqz, core_din_valid}, 0);
    chk("rst_data", {tag ^ core_key, core_din, word_cnt}, 0);
    #2 arstn = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {busy, msg_ready}, 0);

    // Reset while in ABS_A.
    start = 1; key = rkey();
    @(negedge clk);
    start = 0;
    msg_valid = 1; msg_data = {$urandom(), $urandom()}; msg_last = 0;
    n = 0;
    while (!(core_din_valid && !core_sqz) && n < 20) begin @(negedge clk); n++; end
    chk("reach_ABS_A", n < 20, 1);
    msg_valid = 0;
    #2 arstn = 1'b1;
    #1;
    chk("midrst_ctrl", {busy, msg_ready, tag_valid, core_init, core_sqz, core_din_valid}, 0);
    chk("midrst_key", core_key, 0);
    chk("midrst_din_cnt", {core_din, word_cnt}, 0);
    @(negedge clk); #2 arstn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_pulse_after_rst", {core_init, core_din_valid, core_sqz, busy}, 0);
    end

    // Directed vector table.
    foreach (tbl[i])
      run_msg(tbl[i].n, tbl[i].gmax, tbl[i].tdelay, tbl[i].noise, tbl[i].fixed,
              tbl[i].cnt, tbl[i].cnt2);

    // Randomized messages against the reference model.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 7);
      run_msg(n, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0,
              n, (n > 3) ? 3 : n);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
